// File: rtl/led_strobe_gen.sv
// Multi-group strobe LED driver: each group gets one slot per period with FLASHES on/off flashes then a dark tail.
// Latency: led_out/cycle_done register the pattern of the current counter state (one clock); free-running, no backpressure.
module led_strobe_gen #(
    parameter int LED_W   = 8,
    parameter int GROUPS  = 2,
    parameter int PERIOD  = 240000,
    parameter int FLASHES = 6
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            en,
    input  logic [1:0]                                      mode,
    output logic [LED_W-1:0]                                led_out,
    output logic [((GROUPS > 1) ? $clog2(GROUPS) : 1)-1:0]  slot_idx,
    output logic                                            cycle_done
);

    localparam int SLOT_LEN = PERIOD / GROUPS;
    localparam int HALF     = SLOT_LEN / (2 * FLASHES);
    localparam int GW       = LED_W / GROUPS;
    localparam int NPH      = 2 * FLASHES;
    localparam int IDX_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int SLOT_W   = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int HALF_W   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int PH_W     = (NPH + 1 > 1) ? $clog2(NPH + 1) : 1;

    if (LED_W % GROUPS != 0) begin : g_chk_groups
        $error("led_strobe_gen: LED_W must be a multiple of GROUPS");
    end
    if (HALF < 1) begin : g_chk_half
        $error("led_strobe_gen: PERIOD too short for GROUPS*2*FLASHES");
    end

    typedef enum logic [1:0] {
        M_ALT    = 2'b00,
        M_ALL    = 2'b01,
        M_INV    = 2'b10,
        M_STEADY = 2'b11
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e              r_state;
    mode_e               r_mode_q;
    logic [IDX_W-1:0]    r_slot_idx;
    logic [SLOT_W-1:0]   r_slot_cnt;
    logic [HALF_W-1:0]   r_half_cnt;
    logic [PH_W-1:0]     r_phase;
    logic [LED_W-1:0]    r_led;
    logic                r_cycle_done;

    logic                w_slot_end;
    logic                w_half_end;
    logic                w_last;
    logic                w_on;
    logic [LED_W-1:0]    w_grp;
    logic [LED_W-1:0]    w_pattern;

    assign w_slot_end = (r_slot_cnt == SLOT_W'(SLOT_LEN - 1));
    assign w_half_end = (r_half_cnt == HALF_W'(HALF - 1));
    assign w_last     = w_slot_end && (r_slot_idx == IDX_W'(GROUPS - 1));
    assign w_on       = (r_phase < PH_W'(NPH)) && !r_phase[0];

    always_comb begin
        w_grp = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (r_slot_idx == IDX_W'(g)) begin
                w_grp[g*GW +: GW] = {GW{1'b1}};
            end
        end
    end

    always_comb begin
        w_pattern = '0;
        case (r_mode_q)
            M_ALT:   w_pattern = w_on ? w_grp : '0;
            M_ALL:   w_pattern = w_on ? {LED_W{1'b1}} : '0;
            M_INV:   w_pattern = w_on ? ~w_grp : '0;
            default: w_pattern = {LED_W{1'b1}};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mode_q     <= M_ALT;
            r_slot_idx   <= '0;
            r_slot_cnt   <= '0;
            r_half_cnt   <= '0;
            r_phase      <= '0;
            r_led        <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_led        <= '0;
                    r_cycle_done <= 1'b0;
                    r_slot_idx   <= '0;
                    r_slot_cnt   <= '0;
                    r_half_cnt   <= '0;
                    r_phase      <= '0;
                    if (en) begin
                        r_state  <= S_RUN;
                        r_mode_q <= mode_e'(mode);
                    end
                end
                default: begin
                    if (!en) begin
                        r_state      <= S_IDLE;
                        r_led        <= '0;
                        r_cycle_done <= 1'b0;
                        r_slot_idx   <= '0;
                        r_slot_cnt   <= '0;
                        r_half_cnt   <= '0;
                        r_phase      <= '0;
                    end else begin
                        r_led        <= w_pattern;
                        r_cycle_done <= w_last;
                        // Slot wrap wins over the flash counters; mode only changes on slot boundaries.
                        if (w_slot_end) begin
                            r_slot_cnt <= '0;
                            r_half_cnt <= '0;
                            r_phase    <= '0;
                            r_mode_q   <= mode_e'(mode);
                            r_slot_idx <= (r_slot_idx == IDX_W'(GROUPS - 1)) ? '0 : r_slot_idx + 1'b1;
                        end else begin
                            r_slot_cnt <= r_slot_cnt + 1'b1;
                            if (w_half_end) begin
                                r_half_cnt <= '0;
                                if (r_phase != PH_W'(NPH)) begin
                                    r_phase <= r_phase + 1'b1;
                                end
                            end else begin
                                r_half_cnt <= r_half_cnt + 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign led_out    = r_led;
    assign slot_idx   = r_slot_idx;
    assign cycle_done = r_cycle_done;

endmodule

// File: tb/tb_led_strobe_gen.sv
// Bench for led_strobe_gen: two instances (2 groups / 4 groups) driven by shared inputs and checked
// against a time-index reference model, a vector table and hand-written corner sequences.
module tb_led_strobe_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] led_a, led_b;
    logic       slot_a;
    logic [1:0] slot_b;
    logic       done_a, done_b;

    always #5 clk = ~clk;

    led_strobe_gen #(.LED_W(8), .GROUPS(2), .PERIOD(40), .FLASHES(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .led_out(led_a), .slot_idx(slot_a), .cycle_done(done_a)
    );

    led_strobe_gen #(.LED_W(8), .GROUPS(4), .PERIOD(48), .FLASHES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .led_out(led_b), .slot_idx(slot_b), .cycle_done(done_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: k counts clocks spent running; everything else follows from k by arithmetic.
    int c_g[2]    = '{2, 4};
    int c_sl[2]   = '{20, 12};
    int c_half[2] = '{3, 6};
    int c_fl[2]   = '{3, 1};

    bit         m_run[2];
    int         m_k[2];
    logic [1:0] m_mq[2];
    logic [7:0] m_led[2];
    int         m_slot[2];
    bit         m_done[2];

    function automatic logic [7:0] pat(int d, int k, logic [1:0] mq);
        int s, slot, ph, gw;
        bit on;
        logic [7:0] m;
        s    = k % c_sl[d];
        slot = (k / c_sl[d]) % c_g[d];
        ph   = s / c_half[d];
        if (ph > 2 * c_fl[d]) ph = 2 * c_fl[d];
        on   = (ph < 2 * c_fl[d]) && (ph % 2 == 0);
        gw   = 8 / c_g[d];
        m    = 8'(((1 << gw) - 1) << (slot * gw));
        case (mq)
            2'd0:    return on ? m : 8'h00;
            2'd1:    return on ? 8'hFF : 8'h00;
            2'd2:    return on ? ~m : 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 0; m_k[d] = 0; m_mq[d] = 2'd0;
            m_led[d] = 8'h00; m_slot[d] = 0; m_done[d] = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (!m_run[d]) begin
                m_led[d] = 8'h00; m_done[d] = 0;
                if (en) begin
                    m_run[d] = 1; m_k[d] = 0; m_mq[d] = mode;
                end
            end else if (!en) begin
                m_run[d] = 0; m_led[d] = 8'h00; m_done[d] = 0;
            end else begin
                m_led[d]  = pat(d, m_k[d], m_mq[d]);
                m_done[d] = (m_k[d] % c_sl[d] == c_sl[d] - 1) &&
                            ((m_k[d] / c_sl[d]) % c_g[d] == c_g[d] - 1);
                m_k[d]++;
                if (m_k[d] % c_sl[d] == 0) m_mq[d] = mode;
            end
            m_slot[d] = m_run[d] ? (m_k[d] / c_sl[d]) % c_g[d] : 0;
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("led_a",  32'(led_a),  32'(m_led[0]));
        chk("slot_a", 32'(slot_a), 32'(m_slot[0]));
        chk("done_a", 32'(done_a), 32'(m_done[0]));
        chk("led_b",  32'(led_b),  32'(m_led[1]));
        chk("slot_b", 32'(slot_b), 32'(m_slot[1]));
        chk("done_b", 32'(done_b), 32'(m_done[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_model();
    endtask

    typedef struct {
        logic       en;
        logic [1:0] mode;
        int         n;
        logic [7:0] led;
        logic       done;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] exp_b[4];

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'd0;
        model_reset();
        #12;
        chk("rst_led_a", 32'(led_a), 32'h0);
        chk("rst_slot_a", 32'(slot_a), 32'h0);
        chk("rst_done_a", 32'(done_a), 32'h0);
        chk("rst_led_b", 32'(led_b), 32'h0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Alternate cadence over two periods, then steady mode after an en drop.
        tbl.push_back('{1'b1, 2'd0, 1,  8'h00, 1'b0});
        for (int s = 0; s < 2; s++) begin
            for (int f = 0; f < 2; f++) begin
                tbl.push_back('{1'b1, 2'd0, 3, (s == 0) ? 8'h0F : 8'hF0, 1'b0});
                tbl.push_back('{1'b1, 2'd0, 3, 8'h00, 1'b0});
            end
            tbl.push_back('{1'b1, 2'd0, 3, (s == 0) ? 8'h0F : 8'hF0, 1'b0});
            if (s == 0) tbl.push_back('{1'b1, 2'd0, 5, 8'h00, 1'b0});
            else begin
                tbl.push_back('{1'b1, 2'd0, 4, 8'h00, 1'b0});
                tbl.push_back('{1'b1, 2'd0, 1, 8'h00, 1'b1});
            end
        end
        tbl.push_back('{1'b1, 2'd0, 3,  8'h0F, 1'b0});
        tbl.push_back('{1'b0, 2'd3, 1,  8'h00, 1'b0});
        tbl.push_back('{1'b0, 2'd3, 2,  8'h00, 1'b0});
        tbl.push_back('{1'b1, 2'd3, 1,  8'h00, 1'b0});
        tbl.push_back('{1'b1, 2'd3, 39, 8'hFF, 1'b0});
        tbl.push_back('{1'b1, 2'd3, 1,  8'hFF, 1'b1});
        tbl.push_back('{1'b1, 2'd3, 5,  8'hFF, 1'b0});

        foreach (tbl[i]) begin
            en = tbl[i].en; mode = tbl[i].mode;
            for (int c = 0; c < tbl[i].n; c++) begin
                step();
                chk("tbl_led", 32'(led_a), 32'(tbl[i].led));
                chk("tbl_done", 32'(done_a), 32'(tbl[i].done));
            end
        end

        // Invert, with a mode change mid-slot that must wait for the slot boundary.
        en = 1'b0; step();
        mode = 2'd2; en = 1'b1; step();
        repeat (5) step();
        mode = 2'd1; step();
        step();
        chk("inv_hold", 32'(led_a), 32'hF0);
        repeat (13) step();
        step();
        chk("inv_switch", 32'(led_a), 32'hFF);
        chk("inv_slot", 32'(slot_a), 32'h1);

        // Drop en at slot 1, slot_cnt 7, then restart.
        repeat (6) step();
        en = 1'b0; step();
        chk("drop_led", 32'(led_a), 32'h0);
        chk("drop_slot", 32'(slot_a), 32'h0);
        mode = 2'd0; en = 1'b1; step();
        step();
        chk("restart_led_a", 32'(led_a), 32'h0F);
        chk("restart_led_b", 32'(led_b), 32'h03);

        // Four-group instance rotation and wrap.
        exp_b = '{8'h03, 8'h0C, 8'h30, 8'hC0};
        for (int k = 1; k < 48; k++) begin
            step();
            if (k % 12 == 2) chk("b_on", 32'(led_b), 32'(exp_b[k / 12]));
            if (k % 12 == 8) chk("b_off", 32'(led_b), 32'h0);
            if (k % 12 == 11) chk("b_slot", 32'(slot_b), 32'(((k + 1) / 12) % 4));
        end
        chk("b_done", 32'(done_b), 32'h1);

        // Asynchronous reset mid-flash, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_led_a", 32'(led_a), 32'h0);
        chk("arst_led_b", 32'(led_b), 32'h0);
        chk("arst_slot_b", 32'(slot_b), 32'h0);
        #3 rst_n = 1'b1;

        repeat (4000) begin
            if ($urandom_range(0, 199) == 0) en = ~en;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 799) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                model_reset();
                chk("rnd_arst_a", 32'(led_a), 32'h0);
                chk("rnd_arst_b", 32'(led_b), 32'h0);
                rst_n = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_strobe_gen.md
Name: led_strobe_gen

Overview:
Parametrised multi-group strobe ("police flash") LED driver, the next generation of the fixed 8-LED, two-half strobe driver in the LED mode set.
- The LED bank is split into GROUPS equal groups; each group owns one time slot per period.
- Within its slot, a group produces FLASHES on/off flashes, followed by a dark tail.
- A run-time mode selects alternate, all-together, inverted, or steady patterns.
- Sits beside the other LED mode drivers and feeds the LED output mux.

Parameters:
- LED_W, 8, total LED outputs; must be a multiple of GROUPS.
- GROUPS, 2, number of LED groups (1..LED_W); group g = led_out[g*LED_W/GROUPS +: LED_W/GROUPS].
- PERIOD, 240000, clocks per full cycle covering all slots.
- FLASHES, 6, flashes per slot (>=1).
- Derived: SLOT_LEN = PERIOD/GROUPS; HALF = SLOT_LEN/(2*FLASHES), must be >=1; TAIL = SLOT_LEN - 2*FLASHES*HALF.
- Elaboration fails (static check) if LED_W%GROUPS != 0 or HALF < 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  run enable; level sensitive
- mode  input  2  00 ALTERNATE, 01 ALL, 10 INVERT, 11 STEADY
- led_out  output  LED_W  registered LED drive, 1 = lit
- slot_idx  output  max(1,$clog2(GROUPS))  index of the current slot
- cycle_done  output  1  one-clock pulse on the last clock of the last slot

Behaviour:
Reset (async, rst_n=0):
- led_out=0, slot_idx=0, cycle_done=0, state=IDLE.
- All counters and the latched mode are 0.

FSM, two states:
- IDLE: counters held at 0, led_out<=0. If en=1: go to RUN, latch mode into mode_q, slot_idx=0, slot_cnt=0, half_cnt=0, phase=0.
- RUN: if en=0, go to IDLE next clock; led_out<=0 on that same clock edge; counters cleared.

Counters in RUN, all advancing every clock:
- slot_cnt runs 0..SLOT_LEN-1.
  - At SLOT_LEN-1 it wraps to 0, and slot_idx <= (slot_idx==GROUPS-1) ? 0 : slot_idx+1.
  - mode_q is re-latched from mode at this boundary only; mode changes mid-slot are ignored until the next slot.
- half_cnt runs 0..HALF-1. At HALF-1 it wraps, and phase increments, saturating at 2*FLASHES (the tail).
- phase, half_cnt, and the slot counters reset to 0 whenever slot_cnt wraps.
  - Slot wrap has priority over the half_cnt/phase increment.
  - With TAIL=0, phase never reaches 2*FLASHES.

Pattern (combinational from the current state; led_out registers it, so one clock of latency):
- on = (phase < 2*FLASHES) and (phase is even).
- grp = one-hot mask of group slot_idx, expanded to LED_W.
- ALTERNATE: led_out <= on ? grp : 0.
- ALL: led_out <= on ? all ones : 0.
- INVERT: led_out <= on ? ~grp : 0. With GROUPS=1 this is always 0.
- STEADY: led_out <= all ones; counters still run and cycle_done still pulses.

cycle_done:
- Registered; high for exactly one clock, asserted coincident with led_out for the last clock (slot_idx=GROUPS-1, slot_cnt=SLOT_LEN-1).
- Never asserted in IDLE.

Boundary rules:
- en toggling 1->0->1 always restarts at slot 0, phase 0.
- Reset mid-RUN forces IDLE immediately with led_out=0.

Widths:
- slot_cnt is $clog2(SLOT_LEN) bits; half_cnt is $clog2(HALF) bits; phase is $clog2(2*FLASHES+1) bits; each has a minimum of 1 bit.
- No counter ever exceeds its terminal value.

Test Plan:
Bench parameters: LED_W=8, GROUPS=2, PERIOD=40, FLASHES=3, giving SLOT_LEN=20, HALF=3, TAIL=2.
1. Reset, then en=1, mode=00 at clock 0 -> led_out=0x00 until 2 clocks after en.
   - Then 0x0F for 3 clocks, 0x00 for 3, repeated 3 times; then 0x00 for 2 tail clocks.
   - Then 0xF0 with the same cadence for slot 1.
   - cycle_done pulses once every 40 clocks.
2. mode=01 -> every on half-phase drives 0xFF in both slots; off and tail phases drive 0x00.
3. mode=10 -> slot 0 on-phases drive 0xF0, slot 1 on-phases drive 0x0F.
   - Change mode to 01 at slot_cnt=5: the pattern is unchanged until the slot boundary, then switches.
4. mode=11 -> led_out=0xFF continuously; slot_idx alternates every 20 clocks; cycle_done keeps pulsing.
5. Drop en mid-slot 1 (slot_cnt=7) -> led_out=0x00 next clock.
   - Re-raise en -> restarts at slot_idx=0, phase 0.
   - Assert rst_n=0 mid-flash -> outputs 0 asynchronously, without waiting for a clock edge.
6. GROUPS=4, LED_W=8, PERIOD=48, FLASHES=1 (HALF=6, TAIL=0) -> mode 00 lights 0x03, 0x0C, 0x30, 0xC0 in turn, each 6 on and 6 off.
   - slot_idx runs 0..3 and wraps.
